// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - single-wide fetch stage: PC register, icache capture, in-order fetch queue to decode.
module fetch_stage #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              FQ_DEPTH = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [XLEN-1:0]               Icache2proc_data,
    input  logic                          Icache2proc_valid,
    input  logic                          commit_mis_pred,
    input  logic [XLEN-1:0]               commit_target_pc,
    input  logic                          decode_ready,
    output logic [XLEN-1:0]               proc2Icache_addr,
    output logic                          fetch_valid,
    output logic [XLEN-1:0]               fetch_pc,
    output logic [XLEN-1:0]               fetch_inst,
    output logic [$clog2(FQ_DEPTH):0]     fq_count,
    output logic [31:0]                   miss_cycles
);

    localparam int PW = $clog2(FQ_DEPTH);
    localparam int CW = PW + 1;

    logic [XLEN-1:0] pc_q, pc_d;
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic [31:0]     miss_q, miss_d;

    logic [XLEN-1:0] pc_mem   [FQ_DEPTH];
    logic [XLEN-1:0] inst_mem [FQ_DEPTH];

    logic full, enq, deq;

    assign full = (count_q == CW'(FQ_DEPTH));
    assign deq  = fetch_valid && decode_ready && !commit_mis_pred;
    assign enq  = Icache2proc_valid && !commit_mis_pred && (!full || deq);

    always_comb begin
        pc_d    = pc_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        miss_d  = miss_q;
        if (commit_mis_pred) begin
            pc_d    = {commit_target_pc[XLEN-1:2], 2'b00};
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (enq) begin
                pc_d   = pc_q + XLEN'(4);
                tail_d = tail_q + PW'(1);
            end
            if (deq) begin
                head_d = head_q + PW'(1);
            end
            count_d = count_q + CW'(enq) - CW'(deq);
        end
        // Counts only cycles where a miss is what keeps the queue from filling.
        if (!Icache2proc_valid && !full && !commit_mis_pred && (miss_q != '1)) begin
            miss_d = miss_q + 32'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_q    <= RESET_PC;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            miss_q  <= '0;
        end else begin
            pc_q    <= pc_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            miss_q  <= miss_d;
        end
    end

    always_ff @(posedge clock) begin
        if (enq) begin
            pc_mem[tail_q]   <= pc_q;
            inst_mem[tail_q] <= Icache2proc_data;
        end
    end

    assign proc2Icache_addr = pc_q;
    assign fetch_valid      = (count_q != '0);
    assign fetch_pc         = fetch_valid ? pc_mem[head_q]   : '0;
    assign fetch_inst       = fetch_valid ? inst_mem[head_q] : '0;
    assign fq_count         = count_q;
    assign miss_cycles      = miss_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage: vector table, corner sequences, random vs queue model.
module tb_fetch_stage;

    localparam int FQ_DEPTH = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] Icache2proc_data = '0;
    logic        Icache2proc_valid = 1'b0;
    logic        commit_mis_pred = 1'b0;
    logic [31:0] commit_target_pc = '0;
    logic        decode_ready = 1'b0;
    logic [31:0] proc2Icache_addr;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_inst;
    logic [3:0]  fq_count;
    logic [31:0] miss_cycles;

    fetch_stage #(.XLEN(32), .RESET_PC(32'h0), .FQ_DEPTH(FQ_DEPTH)) dut (
        .clock(clock), .reset(reset),
        .Icache2proc_data(Icache2proc_data), .Icache2proc_valid(Icache2proc_valid),
        .commit_mis_pred(commit_mis_pred), .commit_target_pc(commit_target_pc),
        .decode_ready(decode_ready), .proc2Icache_addr(proc2Icache_addr),
        .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .fetch_inst(fetch_inst),
        .fq_count(fq_count), .miss_cycles(miss_cycles)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: a queue of {pc, inst} pairs, a PC and a miss counter.
    logic [63:0] mq[$];
    logic [31:0] m_pc;
    logic [31:0] m_miss;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pc   = 32'h0;
        m_miss = 32'h0;
    endtask

    task automatic model_step(input logic v, input logic [31:0] d, input logic mis,
                              input logic [31:0] t, input logic dr);
        bit full_now, take, give;
        full_now = (mq.size() == FQ_DEPTH);
        take     = (mq.size() > 0) && dr && !mis;
        give     = v && !mis && (!full_now || take);
        if (!v && !full_now && !mis && m_miss != 32'hFFFF_FFFF) m_miss++;
        if (mis) begin
            mq.delete();
            m_pc = t & 32'hFFFF_FFFC;
        end else begin
            if (take) void'(mq.pop_front());
            if (give) begin
                mq.push_back({m_pc, d});
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic check_model(input string tag);
        logic [63:0] h;
        h = (mq.size() > 0) ? mq[0] : 64'h0;
        chk({tag, ".addr"},  proc2Icache_addr, m_pc);
        chk({tag, ".valid"}, 32'(fetch_valid), 32'(mq.size() > 0));
        chk({tag, ".pc"},    fetch_pc,   h[63:32]);
        chk({tag, ".inst"},  fetch_inst, h[31:0]);
        chk({tag, ".count"}, 32'(fq_count), 32'(mq.size()));
        chk({tag, ".miss"},  miss_cycles, m_miss);
    endtask

    task automatic tick(input logic v, input logic [31:0] d, input logic mis,
                        input logic [31:0] t, input logic dr);
        Icache2proc_valid = v;
        Icache2proc_data  = d;
        commit_mis_pred   = mis;
        commit_target_pc  = t;
        decode_ready      = dr;
        @(posedge clock);
        model_step(v, d, mis, t, dr);
        @(negedge clock);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, ".addr"},  proc2Icache_addr, 32'h0);
        chk({tag, ".valid"}, 32'(fetch_valid), 32'h0);
        chk({tag, ".pc"},    fetch_pc, 32'h0);
        chk({tag, ".inst"},  fetch_inst, 32'h0);
        chk({tag, ".count"}, 32'(fq_count), 32'h0);
        chk({tag, ".miss"},  miss_cycles, 32'h0);
    endtask

    // Asynchronous assertion away from any clock edge, release on a falling edge.
    task automatic do_reset(input string tag);
        @(negedge clock);
        #2;
        reset = 1'b0;
        #1;
        check_reset_values(tag);
        model_reset();
        Icache2proc_valid = 1'b0;
        commit_mis_pred   = 1'b0;
        decode_ready      = 1'b0;
        @(negedge clock);
        reset = 1'b1;
    endtask

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic        mis;
        logic [31:0] t;
        logic        dr;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        logic [3:0]  e_cnt;
        logic [31:0] e_miss;
    } vec_t;

    vec_t tbl[8];

    initial begin
        logic [31:0] miss0;
        tbl[0] = '{1'b1, 32'h13, 1'b0, 32'h0,    1'b0, 32'h4,    1'b1, 32'h0,    32'h13, 4'd1, 32'd0};
        tbl[1] = '{1'b1, 32'hA1, 1'b0, 32'h0,    1'b1, 32'h8,    1'b1, 32'h4,    32'hA1, 4'd1, 32'd0};
        tbl[2] = '{1'b0, 32'h0,  1'b0, 32'h0,    1'b0, 32'h8,    1'b1, 32'h4,    32'hA1, 4'd1, 32'd1};
        tbl[3] = '{1'b1, 32'hB2, 1'b0, 32'h0,    1'b0, 32'hC,    1'b1, 32'h4,    32'hA1, 4'd2, 32'd1};
        tbl[4] = '{1'b1, 32'hC3, 1'b0, 32'h0,    1'b1, 32'h10,   1'b1, 32'h8,    32'hB2, 4'd2, 32'd1};
        tbl[5] = '{1'b1, 32'hEE, 1'b1, 32'h2003, 1'b1, 32'h2000, 1'b0, 32'h0,    32'h0,  4'd0, 32'd1};
        tbl[6] = '{1'b1, 32'hD4, 1'b0, 32'h0,    1'b1, 32'h2004, 1'b1, 32'h2000, 32'hD4, 4'd1, 32'd1};
        tbl[7] = '{1'b0, 32'h0,  1'b0, 32'h0,    1'b1, 32'h2004, 1'b0, 32'h0,    32'h0,  4'd0, 32'd2};

        // Reset held from time zero.
        #3;
        check_reset_values("por");
        model_reset();
        @(negedge clock);
        reset = 1'b1;

        foreach (tbl[i]) begin
            tick(tbl[i].v, tbl[i].d, tbl[i].mis, tbl[i].t, tbl[i].dr);
            chk($sformatf("tbl%0d.addr", i),  proc2Icache_addr, tbl[i].e_addr);
            chk($sformatf("tbl%0d.valid", i), 32'(fetch_valid), 32'(tbl[i].e_valid));
            chk($sformatf("tbl%0d.pc", i),    fetch_pc,   tbl[i].e_pc);
            chk($sformatf("tbl%0d.inst", i),  fetch_inst, tbl[i].e_inst);
            chk($sformatf("tbl%0d.count", i), 32'(fq_count), 32'(tbl[i].e_cnt));
            chk($sformatf("tbl%0d.miss", i),  miss_cycles, tbl[i].e_miss);
        end

        // Streaming: back-to-back delivery of 0,4,...,0x4C.
        do_reset("rst_stream");
        for (int i = 0; i < 20; i++) begin
            tick(1'b1, 32'h1000 + 32'(i), 1'b0, 32'h0, 1'b1);
            chk("stream.pc", fetch_pc, 32'(4 * i));
            chk("stream.cnt_le1", 32'(fq_count <= 4'd1), 32'h1);
        end

        // Full queue, then a single simultaneous enq/deq.
        do_reset("rst_full");
        for (int i = 0; i < 10; i++) tick(1'b1, 32'h5000 + 32'(i), 1'b0, 32'h0, 1'b0);
        chk("full.count", 32'(fq_count), 32'd8);
        chk("full.addr", proc2Icache_addr, 32'h20);
        tick(1'b1, 32'h5555, 1'b0, 32'h0, 1'b1);
        chk("full_ed.count", 32'(fq_count), 32'd8);
        chk("full_ed.addr", proc2Icache_addr, 32'h24);
        chk("full_ed.pc", fetch_pc, 32'h4);
        check_model("full_ed");

        // Miss stall at 0x100.
        tick(1'b0, 32'h0, 1'b1, 32'h100, 1'b0);
        miss0 = miss_cycles;
        for (int i = 0; i < 5; i++) tick(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("miss.addr", proc2Icache_addr, 32'h100);
        chk("miss.delta", miss_cycles - miss0, 32'd5);
        tick(1'b1, 32'hCAFE_0001, 1'b0, 32'h0, 1'b0);
        chk("miss.pc", fetch_pc, 32'h100);
        chk("miss.inst", fetch_inst, 32'hCAFE_0001);

        // Redirect with three entries queued, hit and ready in the pulse cycle.
        tick(1'b1, 32'h2, 1'b0, 32'h0, 1'b0);
        tick(1'b1, 32'h3, 1'b0, 32'h0, 1'b0);
        chk("redir.pre", 32'(fq_count), 32'd3);
        tick(1'b1, 32'h4, 1'b1, 32'h2003, 1'b1);
        chk("redir.count", 32'(fq_count), 32'd0);
        chk("redir.valid", 32'(fetch_valid), 32'd0);
        chk("redir.addr", proc2Icache_addr, 32'h2000);

        // PC wrap at the top of the address space.
        tick(1'b0, 32'h0, 1'b1, 32'hFFFF_FFFF, 1'b0);
        tick(1'b1, 32'hBEEF, 1'b0, 32'h0, 1'b0);
        chk("wrap.addr", proc2Icache_addr, 32'h0);
        chk("wrap.pc", fetch_pc, 32'hFFFF_FFFC);
        check_model("wrap");

        // Randomized run against the model; covers pointer wrap many times over.
        for (int i = 0; i < 3000; i++) begin
            tick(($urandom_range(0, 3) != 0), $urandom, ($urandom_range(0, 24) == 0),
                 $urandom, ($urandom_range(0, 4) < 3));
            check_model("rand");
        end

        // Reset mid-operation with entries queued.
        for (int i = 0; i < 4; i++) tick(1'b1, 32'h77 + 32'(i), 1'b0, 32'h0, 1'b0);
        do_reset("rst_mid");
        tick(1'b1, 32'h13, 1'b0, 32'h0, 1'b0);
        check_model("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Single-wide instruction fetch stage sitting directly downstream of the instruction cache and upstream of decode. Holds the program counter, presents it to the icache every cycle, captures the returned 32-bit instruction when the icache reports a hit, and buffers `{pc, inst}` pairs in an in-order fetch queue. Decode drains the queue over a valid/ready handshake. A commit-time mispredict flushes the queue and redirects the PC.

## Interface
- `RESET_PC`, 0: PC loaded on reset.
- `FQ_DEPTH`, 8: fetch queue entries; power of two, ≥2.
- `clock` in 1: sole clock; all state updates on posedge.
- `reset` in 1: asynchronous, active-low. Asserting it (low) clears all state immediately, independent of `clock`.
- `Icache2proc_data` in `XLEN`: instruction word for the current `proc2Icache_addr`, combinational from the icache.
- `Icache2proc_valid` in 1: hit for the current `proc2Icache_addr`, same cycle.
- `commit_mis_pred` in 1: flush and redirect request.
- `commit_target_pc` in `XLEN`: redirect target; sampled only when `commit_mis_pred`=1.
- `decode_ready` in 1: decode accepts the head entry this cycle.
- `proc2Icache_addr` out `XLEN`: current fetch PC; this is the PC register itself.
- `fetch_valid` out 1: queue head is valid.
- `fetch_pc` out `XLEN`: PC of the queue head.
- `fetch_inst` out `XLEN`: instruction of the queue head.
- `fq_count` out `$clog2(FQ_DEPTH)+1`: current occupancy.
- `miss_cycles` out 32: count of cycles with `Icache2proc_valid`=0 and queue not full. Saturates at 0xFFFFFFFF.

## Operation
- **Enqueue condition (`enq`):** `Icache2proc_valid` && !`commit_mis_pred` && (`fq_count` < `FQ_DEPTH` || `deq`).
  - Writes `{proc2Icache_addr, Icache2proc_data}` at the tail.
  - Next cycle the PC becomes PC+4, computed modulo 2^`XLEN`, so it wraps.
- **Dequeue condition (`deq`):** `fetch_valid` && `decode_ready` && !`commit_mis_pred`. Advances the head.
- **Simultaneous enq and deq:**
  - When full, both occur and `fq_count` is unchanged.
  - When empty, `deq` is impossible. The enqueued entry becomes visible the next cycle; there is no bypass.
- **Stall:** if `Icache2proc_valid`=0, or the queue is full without a `deq`, the PC holds. The icache performs its own miss handling based on the unchanged address.
- **Redirect:** when `commit_mis_pred`=1:
  - Next cycle the PC is `commit_target_pc` with bits [1:0] forced to 0.
  - Head, tail and count are cleared.
  - `enq` and `deq` are suppressed in that cycle. Decode discards any handshake in the mispredict cycle.
- **Pointers:** head and tail are `$clog2(FQ_DEPTH)` bits and wrap naturally. Full/empty are determined by `fq_count` only.
- **`miss_cycles` increment:** when `Icache2proc_valid`=0 && `fq_count` < `FQ_DEPTH` && !`commit_mis_pred`.
- **State:** PC register, FQ_DEPTH×2×`XLEN` storage, head, tail, count, and the miss counter. There is no other FSM; the behaviour is RUN with implicit STALL and FLUSH conditions as above.

## Timing
- **Reset values** (while `reset`=0):
  - `proc2Icache_addr`=`RESET_PC`.
  - `fetch_valid`=0, `fetch_pc`=0, `fetch_inst`=0.
  - `fq_count`=0, `miss_cycles`=0.
  - Queue storage contents are don't-care but must read as 0 on outputs when empty.
- **Reset deassertion:** the first `enq` can occur on the first posedge after deassertion, provided `Icache2proc_valid`=1.
- **Fetch to decode latency:** an instruction hitting in cycle N appears on `fetch_*` in cycle N+1 (empty queue, no redirect).
- **Throughput:** one instruction per cycle sustained when the icache hits and decode is ready.
- **Redirect timing:** `commit_mis_pred` in cycle N gives `proc2Icache_addr`=target and `fetch_valid`=0 in cycle N+1. The earliest new entry is visible in N+2.
- **Reset mid-operation:** the asynchronous assertion immediately forces all reset values, regardless of any redirect or handshake in flight.
- **Output paths:** `fetch_*` outputs are driven from queue storage and pointer registers only, with no combinational path from `decode_ready`. `proc2Icache_addr` is a register output.

## Test plan
- **Reset and first fetch:** `RESET_PC`=0; drive `reset` low mid-cycle → all outputs at reset values immediately. Release with `Icache2proc_valid`=1 and data 0x00000013 → next cycle `fetch_valid`=1, `fetch_pc`=0, `fetch_inst`=0x13, `proc2Icache_addr`=4.
- **Streaming:** constant hits with `decode_ready`=1 for 20 cycles → PCs 0,4,…,0x4C delivered back-to-back; `fq_count` stays ≤1.
- **Full queue:** `decode_ready`=0 with constant hits → `fq_count` reaches 8 and the PC holds at 0x20. Raise `decode_ready` for one cycle → simultaneous enq/deq, `fq_count` stays 8, PC becomes 0x24.
- **Miss stall:** `Icache2proc_valid`=0 for 5 cycles at PC 0x100 → PC holds at 0x100 and `miss_cycles` increments by 5. Then a hit → entry `{0x100, data}` is enqueued.
- **Redirect:** with 3 entries queued, pulse `commit_mis_pred` with target 0x2003 while `Icache2proc_valid`=1 and `decode_ready`=1 → next cycle `fq_count`=0, `fetch_valid`=0, PC=0x2000, and neither enq nor deq occurs in the pulse cycle.
- **Wrap-around:** PC=0xFFFFFFFC with a hit → next PC=0x0. Also run more than 2×`FQ_DEPTH` enqueues and dequeues → FIFO order is preserved across pointer wrap.
